user_word_sequencer: RTL
========================

# user_word_sequencer

Multi-channel, registered successor to the single-channel user-word-count decoder. It holds per-channel mode, configuration and page state, and accepts per-channel sequencing requests. For each request it decodes the user-word count and emits that many indexed word strobes over a ready/valid handshake. It sits between the emulation-mode configuration registers and the user-word fetch path.

## Interface
Parameters:
- `NUM_CH`, 4: number of independent channels (1..16).
- `CNT_W`, 4: width of the count and index outputs (≥4).
- `CH_W`, `$clog2(NUM_CH)` (minimum 1): channel-select width. Derived; not overridden.

Ports:
- `i_clk` in 1: sole clock; all logic is on the rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_cfg_we` in 1: config write strobe.
- `i_cfg_ch` in `CH_W`: channel to write.
- `i_cfg_mode` in 2: `uws_mode_e` (NONE=0, SU=1, EM=2, ATA=3).
- `i_cfg` in 7: channel cfg field.
- `i_cfg_page` in 1: channel page bit.
- `i_req_valid` in 1: sequencing request.
- `i_req_ch` in `CH_W`: requested channel.
- `o_req_ready` out 1: request accepted when `o_req_ready` and `i_req_valid` are both high.
- `o_word_valid` out 1: word strobe valid.
- `i_word_ready` in 1: downstream accepts the word.
- `o_word_idx` out `CNT_W`: 0-based index of the current word.
- `o_word_last` out 1: current word is the final word.
- `o_done` out 1: one-cycle completion pulse.
- `o_done_cnt` out `CNT_W`: number of words emitted for the finished request.
- `o_done_err` out 1: request named a channel ≥ `NUM_CH`.

## Operation
- Config bank: `NUM_CH` entries, each holding {mode, cfg, page}.
  - Reset value: mode NONE, cfg 0, page 0.
  - Written when `i_cfg_we` is high. A write with `i_cfg_ch` ≥ `NUM_CH` is dropped.
- Decode (pure function, values 0..8):
  - NONE → 0. SU → 0.
  - EM, keyed on cfg[3:0]: 5→0, 6→1, 7→2, 8→3, 9→4, A→5, B→6, C→7, D→8; any other value → 3.
  - ATA, keyed on cfg[6:4]: 0→0, 1→0, 2→1, 3→2.
  - ATA, cfg[6:4] 4..7: page=1 → 2; page=0 → 3, 4, 5, 6 respectively.
  - The result is zero-extended to `CNT_W`.
- FSM states: IDLE, DECODE, EMIT, DONE.
  - IDLE: `o_req_ready` = 1. On accept, latch the channel and go to DECODE.
  - DECODE: read the channel's config bank entry (this includes a write that landed on the accept edge) and latch `cnt`.
    - If the channel is out of range: set err, `cnt` = 0.
    - `cnt` = 0 → go to DONE; otherwise → EMIT with `idx` = 0.
  - EMIT: `o_word_valid` = 1 and `o_word_last` = (`idx` == `cnt` − 1).
    - On a transfer, `idx` increments.
    - On the last transfer, go to DONE.
  - DONE: `o_done` = 1, `o_done_cnt` = `cnt`, `o_done_err` = err. Next state is IDLE.
- The count is snapshotted in DECODE. Config writes to the active channel during EMIT do not affect the request in flight.
- Outputs are stable while `o_word_valid` is high and `i_word_ready` is low.

## Timing
- Reset values:
  - FSM in IDLE.
  - `o_req_ready` = 1.
  - `o_word_valid`, `o_word_last`, `o_done`, `o_done_err` = 0.
  - `o_word_idx` = 0, `o_done_cnt` = 0.
  - Config bank cleared.
- Request accepted at edge T:
  - DECODE during cycle T+1.
  - First `o_word_valid` in cycle T+2.
  - Zero-count request: `o_done` in T+2.
- Words stream at one per cycle when `i_word_ready` is held high. A count of N gives `o_done` at T+2+N.
- `o_req_ready` is low from T+1 until the cycle after DONE. Minimum request-to-request spacing is N+3 cycles (3 when N=0).
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Reset asserted mid-EMIT: outputs and state return to reset values immediately (asynchronous). No `o_done` is issued for the aborted request.

## Structure
- Package `uws_pkg` holds:
  - the `uws_mode_e` enum;
  - the `uws_state_e` enum;
  - the localparam for the EM default count (3) and the ATA paged count (2);
  - the decode function `uws_decode(mode, cfg, page)`.
- One sub-module, `uws_cfg_bank`: the `NUM_CH`-entry register bank, with a write port and an asynchronous read port.
- The top level contains the FSM, counters and the output registers.

## Test plan
- Channel 0 = EM, cfg 0x06; request channel 0 → one word, idx 0, last = 1. `o_done_cnt` = 1 at T+3.
- Channel 1 = ATA, cfg 0x60, page 1 → 2 words. Rewrite with page 0 and re-request → 5 words (idx 0..4, last on 4).
- Channel 2 = SU, and separately channel 3 = EM with cfg 0x0F → SU: `o_done` at T+2 with cnt 0. EM 0x0F: 3 words.
- Channel 1 = EM, cfg 0x0D (8 words); drop `i_word_ready` for 3 cycles at idx 4 → idx, valid and last are held. Still exactly 8 words, `o_done` 3 cycles later.
- `NUM_CH` = 3, request channel 3 → no words, `o_done` = 1, `o_done_err` = 1, cnt 0.
- Config write to the active channel during EMIT → current count unchanged. Assert `i_rst_n` = 0 at idx 2 → all outputs zero, no `o_done`, ready = 1 after release.

Source files
------------

// File: rtl/uws_pkg.sv
// Shared types and the user-word count decode for the user word sequencer.
package uws_pkg;

    typedef enum logic [1:0] {
        UWS_NONE = 2'd0,
        UWS_SU   = 2'd1,
        UWS_EM   = 2'd2,
        UWS_ATA  = 2'd3
    } uws_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EMIT   = 2'd2,
        ST_DONE   = 2'd3
    } uws_state_e;

    localparam logic [3:0] UWS_EM_DEF_CNT   = 4'd3;
    localparam logic [3:0] UWS_ATA_PAGE_CNT = 4'd2;

    function automatic logic [3:0] uws_decode(input uws_mode_e mode,
                                              input logic [6:0] cfg,
                                              input logic       page);
        logic [3:0] cnt;
        cnt = 4'd0;
        case (mode)
            UWS_EM: begin
                if (cfg[3:0] >= 4'h5 && cfg[3:0] <= 4'hD)
                    cnt = cfg[3:0] - 4'd5;
                else
                    cnt = UWS_EM_DEF_CNT;
            end
            UWS_ATA: begin
                case (cfg[6:4])
                    3'd0, 3'd1: cnt = 4'd0;
                    3'd2:       cnt = 4'd1;
                    3'd3:       cnt = 4'd2;
                    // codes 4..7 map to 3..6 unless the page bit selects the paged count
                    default:    cnt = page ? UWS_ATA_PAGE_CNT : ({1'b0, cfg[6:4]} - 4'd1);
                endcase
            end
            default: cnt = 4'd0;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/uws_cfg_bank.sv
// Per-channel {mode, cfg, page} register bank; one write port, one asynchronous read port.
module uws_cfg_bank
    import uws_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_we,
    input  logic [CH_W-1:0] i_wr_ch,
    input  uws_mode_e       i_wr_mode,
    input  logic [6:0]      i_wr_cfg,
    input  logic            i_wr_page,
    input  logic [CH_W-1:0] i_rd_ch,
    output uws_mode_e       o_rd_mode,
    output logic [6:0]      o_rd_cfg,
    output logic            o_rd_page,
    output logic            o_rd_hit
);

    localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

    uws_mode_e  mode_q [NUM_CH];
    logic [6:0] cfg_q  [NUM_CH];
    logic       page_q [NUM_CH];

    logic wr_hit;
    assign wr_hit   = i_we && ({1'b0, i_wr_ch} < NUM_CH_L);
    assign o_rd_hit = ({1'b0, i_rd_ch} < NUM_CH_L);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= UWS_NONE;
                cfg_q[i]  <= 7'd0;
                page_q[i] <= 1'b0;
            end
        end else if (wr_hit) begin
            mode_q[i_wr_ch] <= i_wr_mode;
            cfg_q[i_wr_ch]  <= i_wr_cfg;
            page_q[i_wr_ch] <= i_wr_page;
        end
    end

    // Out-of-range reads return the reset entry so the index never leaves the array.
    always_comb begin
        o_rd_mode = UWS_NONE;
        o_rd_cfg  = 7'd0;
        o_rd_page = 1'b0;
        if (o_rd_hit) begin
            o_rd_mode = mode_q[i_rd_ch];
            o_rd_cfg  = cfg_q[i_rd_ch];
            o_rd_page = page_q[i_rd_ch];
        end
    end

endmodule

// File: rtl/user_word_sequencer.sv
// Multi-channel user-word sequencer: decodes a channel's word count and streams indexed word strobes.
// state  | meaning
// IDLE   | ready for a request
// DECODE | snapshot channel config into the word count
// EMIT   | present words idx 0..cnt-1 over valid/ready
// DONE   | one-cycle completion pulse with count and error
module user_word_sequencer
    import uws_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cfg_we,
    input  logic [CH_W-1:0]  i_cfg_ch,
    input  uws_mode_e        i_cfg_mode,
    input  logic [6:0]       i_cfg,
    input  logic             i_cfg_page,
    input  logic             i_req_valid,
    input  logic [CH_W-1:0]  i_req_ch,
    output logic             o_req_ready,
    output logic             o_word_valid,
    input  logic             i_word_ready,
    output logic [CNT_W-1:0] o_word_idx,
    output logic             o_word_last,
    output logic             o_done,
    output logic [CNT_W-1:0] o_done_cnt,
    output logic             o_done_err
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    uws_state_e       state_q;
    logic [CH_W-1:0]  ch_q;
    logic [CNT_W-1:0] cnt_q, idx_q, done_cnt_q;
    logic             err_q, ready_q, valid_q, last_q, done_q, done_err_q;

    uws_mode_e        rd_mode;
    logic [6:0]       rd_cfg;
    logic             rd_page, rd_hit;
    logic [CNT_W-1:0] dec_cnt, idx_d;

    uws_cfg_bank #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_cfg_bank (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_we      (i_cfg_we),
        .i_wr_ch   (i_cfg_ch),
        .i_wr_mode (i_cfg_mode),
        .i_wr_cfg  (i_cfg),
        .i_wr_page (i_cfg_page),
        .i_rd_ch   (ch_q),
        .o_rd_mode (rd_mode),
        .o_rd_cfg  (rd_cfg),
        .o_rd_page (rd_page),
        .o_rd_hit  (rd_hit)
    );

    assign dec_cnt = CNT_W'(uws_decode(rd_mode, rd_cfg, rd_page));
    assign idx_d   = idx_q + ONE;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            done_cnt_q <= '0;
            done_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        ch_q    <= i_req_ch;
                        ready_q <= 1'b0;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    cnt_q <= rd_hit ? dec_cnt : '0;
                    err_q <= !rd_hit;
                    idx_q <= '0;
                    if (!rd_hit || dec_cnt == '0) begin
                        state_q    <= ST_DONE;
                        done_q     <= 1'b1;
                        done_cnt_q <= '0;
                        done_err_q <= !rd_hit;
                    end else begin
                        state_q <= ST_EMIT;
                        valid_q <= 1'b1;
                        last_q  <= (dec_cnt == ONE);
                    end
                end
                ST_EMIT: begin
                    if (i_word_ready) begin
                        if (last_q) begin
                            state_q    <= ST_DONE;
                            valid_q    <= 1'b0;
                            last_q     <= 1'b0;
                            idx_q      <= '0;
                            done_q     <= 1'b1;
                            done_cnt_q <= cnt_q;
                            done_err_q <= err_q;
                        end else begin
                            idx_q  <= idx_d;
                            last_q <= (idx_d == cnt_q - ONE);
                        end
                    end
                end
                default: begin
                    done_q     <= 1'b0;
                    done_cnt_q <= '0;
                    done_err_q <= 1'b0;
                    ready_q    <= 1'b1;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready  = ready_q;
    assign o_word_valid = valid_q;
    assign o_word_idx   = idx_q;
    assign o_word_last  = last_q;
    assign o_done       = done_q;
    assign o_done_cnt   = done_cnt_q;
    assign o_done_err   = done_err_q;

endmodule
